div_unit: RTL and testbench



---
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit signed divider: restoring division on operand magnitudes,
// one quotient bit per cycle, sign fix-up, then a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV
// RUN   | 32 restoring iterations, MSB first
// FIX   | apply quotient sign, publish result
// DONE  | ready pulse goes out on the following cycle
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        data_busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // The remainder never reaches |B| (at most 2^31), so 32 bits hold it.
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] result_q, result_d;
    logic        neg_q, neg_d;
    logic        err_q, err_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    logic        b_nz;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_sh;
    logic [32:0] trial;

    always_comb begin
        b_nz   = |data_operandB;
        ovf    = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        abs_a  = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        abs_b  = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
        rem_sh = {rem_q, quo_q[31]};
        trial  = rem_sh - {1'b0, dvs_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            RUN: begin
                rem_d = trial[32] ? rem_sh[31:0] : trial[31:0];
                quo_d = {quo_q[30:0], ~trial[32]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                result_d = neg_q ? (~quo_q + 32'd1) : quo_q;
                exc_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
                if (err_q) exc_d = 1'b1;
            end
            default: ;
        endcase

        // A start always wins over the current operation; a pending DONE
        // still emits its pulse because rdy_d is left untouched here.
        if (ctrl_DIV) begin
            result_d = 32'd0;
            exc_d    = 1'b0;
            cnt_d    = 6'd0;
            rem_d    = 32'd0;
            if (!b_nz || ovf) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                err_d   = 1'b0;
                quo_d   = abs_a;
                dvs_d   = abs_b;
                neg_d   = data_operandA[31] ^ data_operandB[31];
                state_d = RUN;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            result_q <= 32'd0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_busy      = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a truncating signed-divide
// model, with expected results queued at start and compared at ready.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    div_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t model(logic [31:0] x, logic [31:0] y);
        exp_t      e;
        int signed sx;
        int signed sy;
        sx = x;
        sy = y;
        if (y == 32'd0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 1;
        end else begin
            e.res = sx / sy;
            e.exc = 1'b0;
            e.lat = 34;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after the sampling edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        tick();
        ctrl_DIV      = 1'b0;
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back(model(a, b));
        start_op(a, b);
        check({tag, " busy_e0"}, 32'(data_busy), 32'd1);
        check({tag, " clr_res_e0"}, data_result, 32'd0);
        check({tag, " clr_exc_e0"}, 32'(data_exception), 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (data_resultRDY) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, " rdy_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        check({tag, " latency"}, lat, e.lat);
        check({tag, " result"}, data_result, e.res);
        check({tag, " exception"}, 32'(data_exception), 32'(e.exc));
        check({tag, " busy_at_rdy"}, 32'(data_busy), 32'd0);
        tick();
        check({tag, " rdy_width"}, 32'(data_resultRDY), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          any_rdy;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        tick();
        tick();
        check("rst result", data_result, 32'd0);
        check("rst exception", 32'(data_exception), 32'd0);
        check("rst rdy", 32'(data_resultRDY), 32'd0);
        check("rst busy", 32'(data_busy), 32'd0);
        reset = 1'b0;
        tick();

        do_div(32'd7, 32'd2, "7/2");
        repeat (3) tick();
        check("hold result", data_result, 32'd3);
        do_div(-32'sd7, 32'd2, "-7/2");
        do_div(32'd7, -32'sd2, "7/-2");
        do_div(-32'sd7, -32'sd2, "-7/-2");
        do_div(32'd123, 32'd0, "123/0");
        repeat (2) tick();
        check("hold exception", 32'(data_exception), 32'd1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        do_div(32'h8000_0000, 32'd2, "min/2");
        do_div(32'h7FFF_FFFF, 32'd1, "max/1");
        do_div(32'd5, 32'd9, "5/9");
        do_div(32'h8000_0000, 32'h8000_0000, "min/min");

        // Restart at E10: only the second operation may report.
        start_op(32'd100, 32'd7);
        any_rdy = 1'b0;
        repeat (9) begin
            tick();
            if (data_resultRDY) any_rdy = 1'b1;
        end
        check("abort no_early_rdy", 32'(any_rdy), 32'd0);
        do_div(32'd50, 32'd5, "restart 50/5");

        // Reset at E20 of an in-flight divide.
        start_op(32'd1000, 32'd3);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst result", data_result, 32'd0);
        check("midrst exception", 32'(data_exception), 32'd0);
        check("midrst busy", 32'(data_busy), 32'd0);
        check("midrst rdy", 32'(data_resultRDY), 32'd0);
        any_rdy = 1'b0;
        repeat (40) begin
            tick();
            if (data_resultRDY || data_busy) any_rdy = 1'b1;
        end
        check("midrst quiet", 32'(any_rdy), 32'd0);
        do_div(32'd9, 32'd3, "post_rst 9/3");

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = 32'd0 - $urandom_range(1, 20);
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            do_div(ra, rb, "rand");
        end

        check("sb empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
